// File: rtl/spi_pkg.sv
// Shared definitions for the SPI command decoder: FSM encoding, command-byte
// layout and the default status identifier.
package spi_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CMD,
        ST_WR,
        ST_RD,
        ST_DRAIN
    } state_e;

    localparam int         CMD_WR_BIT    = 7;
    localparam logic [6:0] STATUS_ID_DEF = 7'h5A;

endpackage

// File: rtl/sync2.sv
// Generic two-flop synchronizer for asynchronous pad inputs; the reset value
// is chosen per instance so idle-high inputs do not glitch out of reset.
module sync2 #(
    parameter logic RST_VAL = 1'b0
) (
    input  logic clk,
    input  logic rst_n,
    input  logic d_i,
    output logic q_o
);

    logic meta_q;
    logic sync_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta_q <= RST_VAL;
            sync_q <= RST_VAL;
        end else begin
            meta_q <= d_i;
            sync_q <= meta_q;
        end
    end

    assign q_o = sync_q;

endmodule

// File: rtl/spi_reg_bridge.sv
// Turns SPI byte strobes into auto-incrementing single-byte register bus
// reads/writes, and feeds the shifter a status byte or prefetched read data.
//   state    | meaning
//   IDLE     | no transaction; tx_byte shows status
//   CMD      | waiting for the command byte
//   WR       | each byte becomes a write at ptr
//   RD       | each byte prefetches a read at ptr
//   DRAIN    | transaction ended with a request outstanding; wait for ack
module spi_reg_bridge
    import spi_pkg::*;
#(
    parameter int         AW        = 7,
    parameter logic [6:0] STATUS_ID = STATUS_ID_DEF
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          ss,
    input  logic          rx_done,
    input  logic [7:0]    rx_byte,
    output logic [7:0]    tx_byte,
    output logic [AW-1:0] bus_addr,
    output logic [7:0]    bus_wdata,
    output logic          bus_wr,
    output logic          bus_rd,
    input  logic [7:0]    bus_rdata,
    input  logic          bus_ack,
    output logic          busy
);

    logic ss_s;
    logic ss_prev_q;
    logic ss_fall;
    logic eot;

    sync2 #(.RST_VAL(1'b1)) u_ss_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .d_i   (ss),
        .q_o   (ss_s)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) ss_prev_q <= 1'b1;
        else        ss_prev_q <= ss_s;
    end

    assign ss_fall = ss_prev_q & ~ss_s;
    assign eot     = ~ss_prev_q & ss_s;

    state_e        state_q, state_d;
    logic [AW-1:0] ptr_q, ptr_d;
    logic [AW-1:0] addr_q, addr_d;
    logic [7:0]    wdata_q, wdata_d;
    logic [7:0]    tx_q, tx_d;
    logic          wr_q, wr_d;
    logic          rd_q, rd_d;
    logic          err_q, err_d;
    logic          req_out;
    logic          pending;
    logic [AW-1:0] cmd_addr;

    assign req_out  = wr_q | rd_q;
    // An ack landing with rx_done frees the bus for the new byte.
    assign pending  = req_out & ~bus_ack;
    assign cmd_addr = rx_byte[AW-1:0];

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        tx_d    = tx_q;
        wr_d    = wr_q;
        rd_d    = rd_q;
        err_d   = err_q;

        if (bus_ack && req_out) begin
            wr_d = 1'b0;
            rd_d = 1'b0;
            if (rd_q && state_q == ST_RD) tx_d = bus_rdata;
        end

        unique case (state_q)
            ST_IDLE: begin
                tx_d = {err_q, STATUS_ID};
                if (ss_fall) state_d = ST_CMD;
            end
            ST_CMD: begin
                if (rx_done) begin
                    err_d = 1'b0;
                    if (rx_byte[CMD_WR_BIT]) begin
                        ptr_d   = cmd_addr;
                        state_d = ST_WR;
                    end else begin
                        rd_d    = 1'b1;
                        addr_d  = cmd_addr;
                        ptr_d   = cmd_addr + AW'(1);
                        state_d = ST_RD;
                    end
                end
            end
            ST_WR: begin
                if (rx_done) begin
                    if (pending) begin
                        err_d = 1'b1;
                    end else begin
                        wr_d    = 1'b1;
                        addr_d  = ptr_q;
                        wdata_d = rx_byte;
                        ptr_d   = ptr_q + AW'(1);
                    end
                end
            end
            ST_RD: begin
                if (rx_done) begin
                    if (pending) begin
                        err_d = 1'b1;
                    end else begin
                        rd_d   = 1'b1;
                        addr_d = ptr_q;
                        ptr_d  = ptr_q + AW'(1);
                    end
                end
            end
            ST_DRAIN: begin
                if (!req_out || bus_ack) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase

        // End of transaction is applied after the byte in the same cycle.
        if (eot && (state_q == ST_CMD || state_q == ST_WR || state_q == ST_RD)) begin
            state_d = (wr_d | rd_d) ? ST_DRAIN : ST_IDLE;
            tx_d    = {err_d, STATUS_ID};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            ptr_q   <= '0;
            addr_q  <= '0;
            wdata_q <= '0;
            tx_q    <= {1'b0, STATUS_ID};
            wr_q    <= 1'b0;
            rd_q    <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            tx_q    <= tx_d;
            wr_q    <= wr_d;
            rd_q    <= rd_d;
            err_q   <= err_d;
        end
    end

    assign tx_byte   = tx_q;
    assign bus_addr  = addr_q;
    assign bus_wdata = wdata_q;
    assign bus_wr    = wr_q;
    assign bus_rd    = rd_q;
    assign busy      = (state_q != ST_IDLE);

endmodule

// File: tb/tb_spi_reg_bridge.sv
// Scoreboard bench for spi_reg_bridge: stimulus pushes expected bus requests
// and shifter-load bytes; independent monitors pop and compare them.
module tb_spi_reg_bridge;

    localparam logic [6:0] STATUS = 7'h5A;
    localparam int BYTE_GAP = 16;

    typedef struct packed {
        logic       wr;
        logic [6:0] addr;
        logic [7:0] data;
    } bus_t;

    logic       clk;
    logic       rst_n;
    logic       ss;
    logic       rx_done;
    logic [7:0] rx_byte;
    logic [7:0] tx_byte;
    logic [6:0] bus_addr;
    logic [7:0] bus_wdata;
    logic       bus_wr;
    logic       bus_rd;
    logic [7:0] bus_rdata;
    logic       bus_ack;
    logic       busy;

    spi_reg_bridge #(.AW(7), .STATUS_ID(STATUS)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .ss        (ss),
        .rx_done   (rx_done),
        .rx_byte   (rx_byte),
        .tx_byte   (tx_byte),
        .bus_addr  (bus_addr),
        .bus_wdata (bus_wdata),
        .bus_wr    (bus_wr),
        .bus_rd    (bus_rd),
        .bus_rdata (bus_rdata),
        .bus_ack   (bus_ack),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    bus_t       exp_bus[$];
    logic [7:0] exp_tx[$];
    logic [7:0] mem[128];
    logic [7:0] ref_mem[128];
    logic [7:0] txn_q[$];
    logic       err_m;
    int         ack_dly;
    logic       stall;

    function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endfunction

    function automatic bus_t mk(input logic wr, input logic [6:0] a, input logic [7:0] d);
        bus_t e;
        e.wr = wr; e.addr = a; e.data = d;
        return e;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Bus slave: acks each request after ack_dly cycles unless stalled.
    initial begin
        int cnt;
        cnt = 0;
        bus_ack = 1'b0;
        bus_rdata = 8'h00;
        forever begin
            step();
            if (bus_ack) begin
                bus_ack = 1'b0;
                cnt = 0;
            end else if (bus_rd || bus_wr) begin
                if (!stall) begin
                    if (cnt >= ack_dly) begin
                        bus_ack = 1'b1;
                        bus_rdata = mem[bus_addr];
                        if (bus_wr) mem[bus_addr] = bus_wdata;
                    end else begin
                        cnt++;
                    end
                end
            end else begin
                cnt = 0;
            end
        end
    end

    // Monitor: compares every new bus request and every shifter load.
    initial begin
        logic       prev_req, prev_ack, req;
        logic [6:0] prev_addr;
        logic [7:0] prev_wdata;
        bus_t       e;
        prev_req = 1'b0; prev_ack = 1'b0; prev_addr = '0; prev_wdata = '0;
        forever begin
            @(negedge clk);
            req = bus_rd | bus_wr;
            if (rst_n) begin
                if (rx_done) begin
                    if (exp_tx.size() == 0) chk("tx_unexpected", 1, 0);
                    else chk("tx_load", tx_byte, exp_tx.pop_front());
                end
                if (req && (!prev_req || prev_ack)) begin
                    chk("rd_wr_excl", bus_rd & bus_wr, 0);
                    if (exp_bus.size() == 0) begin
                        chk("req_unexpected", {bus_wr, bus_addr}, 0);
                    end else begin
                        e = exp_bus.pop_front();
                        chk("req_kind", bus_wr, e.wr);
                        chk("req_addr", bus_addr, e.addr);
                        if (e.wr) chk("req_wdata", bus_wdata, e.data);
                    end
                end else if (req && prev_req) begin
                    chk("req_stable", {bus_addr, bus_wdata}, {prev_addr, prev_wdata});
                end
            end
            prev_req = rst_n ? req : 1'b0;
            prev_ack = bus_ack;
            prev_addr = bus_addr;
            prev_wdata = bus_wdata;
        end
    end

    task automatic send_byte(input logic [7:0] b, input int gap);
        rx_byte = b;
        rx_done = 1'b1;
        step();
        rx_done = 1'b0;
        rx_byte = 8'($urandom);
        repeat (gap - 1) step();
    endtask

    task automatic ss_start();
        ss = 1'b0;
        repeat (6) step();
    endtask

    task automatic ss_stop(input logic [7:0] st_exp);
        ss = 1'b1;
        for (int i = 0; i < 200 && busy; i++) step();
        repeat (2) step();
        chk("idle_busy", busy, 0);
        chk("idle_status", tx_byte, st_exp);
    endtask

    // Reference model: expected requests and MISO bytes from transaction rules.
    task automatic run_txn();
        logic [7:0] st;
        logic       wr;
        logic [6:0] a, ak;
        st = {err_m, STATUS};
        wr = txn_q[0][7];
        a  = txn_q[0][6:0];
        ss_start();
        chk("miso_first", tx_byte, st);
        for (int k = 0; k < txn_q.size(); k++) begin
            if (k == 0) begin
                exp_tx.push_back(st);
            end else if (wr) begin
                exp_tx.push_back(st);
            end else begin
                ak = a + 7'(k - 1);
                exp_tx.push_back(ref_mem[ak]);
            end
            if (wr && k > 0) begin
                ak = a + 7'(k - 1);
                exp_bus.push_back(mk(1'b1, ak, txn_q[k]));
                ref_mem[ak] = txn_q[k];
            end else if (!wr) begin
                ak = a + 7'(k);
                exp_bus.push_back(mk(1'b0, ak, 8'h00));
            end
            if (k == 0) err_m = 1'b0;
            send_byte(txn_q[k], BYTE_GAP);
        end
        repeat (4) step();
        ss_stop({err_m, STATUS});
    endtask

    initial begin
        logic [7:0] v;
        int n;
        rst_n = 1'b0; ss = 1'b1; rx_done = 1'b0; rx_byte = 8'h00;
        stall = 1'b0; ack_dly = 2; err_m = 1'b0;
        for (int i = 0; i < 128; i++) begin
            v = 8'($urandom);
            mem[i] = v;
            ref_mem[i] = v;
        end
        mem[8'h10] = 8'hAB; ref_mem[8'h10] = 8'hAB;
        mem[8'h11] = 8'hCD; ref_mem[8'h11] = 8'hCD;

        repeat (3) step();
        chk("rst_tx", tx_byte, 8'h5A);
        chk("rst_wr_rd", {bus_wr, bus_rd}, 0);
        chk("rst_addr_wdata", {bus_addr, bus_wdata}, 0);
        chk("rst_busy", busy, 0);
        rst_n = 1'b1;
        repeat (3) step();

        // write burst
        ack_dly = 2;
        txn_q = '{8'h85, 8'h11, 8'h22, 8'h33};
        run_txn();

        // read burst
        txn_q = '{8'h10, 8'h00, 8'h00, 8'h00};
        run_txn();

        // address wrap
        txn_q = '{8'hFE, 8'hA1, 8'hA2, 8'hA3};
        run_txn();

        // overrun: second data byte dropped, ptr held, err reported next time
        ss_start();
        stall = 1'b1;
        exp_tx.push_back(8'h5A);
        send_byte(8'hA0, BYTE_GAP);
        exp_tx.push_back(8'h5A);
        exp_bus.push_back(mk(1'b1, 7'h20, 8'h44));
        ref_mem[7'h20] = 8'h44;
        send_byte(8'h44, 4);
        exp_tx.push_back(8'h5A);
        send_byte(8'h55, 4);
        stall = 1'b0;
        repeat (BYTE_GAP) step();
        exp_tx.push_back(8'h5A);
        exp_bus.push_back(mk(1'b1, 7'h21, 8'h66));
        ref_mem[7'h21] = 8'h66;
        send_byte(8'h66, BYTE_GAP);
        err_m = 1'b1;
        ss_stop(8'hDA);
        txn_q = '{8'hB0, 8'h77};
        run_txn();

        // end of transaction with a read still waiting
        ack_dly = 10;
        ss_start();
        exp_tx.push_back(8'h5A);
        exp_bus.push_back(mk(1'b0, 7'h40, 8'h00));
        send_byte(8'h40, 1);
        ss = 1'b1;
        repeat (5) step();
        chk("drain_hold", {busy, bus_rd, tx_byte}, {1'b1, 1'b1, 8'h5A});
        for (int i = 0; i < 100 && busy; i++) step();
        chk("drain_done", {busy, bus_rd, tx_byte}, {1'b0, 1'b0, 8'h5A});

        // asynchronous reset with a write held on the bus
        ack_dly = 2;
        ss_start();
        stall = 1'b1;
        exp_tx.push_back(8'h5A);
        send_byte(8'hD0, BYTE_GAP);
        exp_tx.push_back(8'h5A);
        exp_bus.push_back(mk(1'b1, 7'h50, 8'h99));
        send_byte(8'h99, 4);
        chk("pre_rst_wr", bus_wr, 1);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_tx", tx_byte, 8'h5A);
        chk("arst_wr_rd", {bus_wr, bus_rd}, 0);
        chk("arst_addr_wdata", {bus_addr, bus_wdata}, 0);
        chk("arst_busy", busy, 0);
        ss = 1'b1;
        stall = 1'b0;
        repeat (3) step();
        rst_n = 1'b1;
        repeat (3) step();
        err_m = 1'b0;
        txn_q = '{8'h50, 8'h00};
        run_txn();

        // randomized transactions
        for (int t = 0; t < 14; t++) begin
            ack_dly = $urandom_range(0, 6);
            n = $urandom_range(0, 4);
            txn_q = {};
            txn_q.push_back(8'($urandom));
            for (int k = 0; k < n; k++) txn_q.push_back(8'($urandom));
            run_txn();
        end

        repeat (10) step();
        chk("bus_queue_empty", exp_bus.size(), 0);
        chk("tx_queue_empty", exp_tx.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("CHECKS %0d ERRORS %0d", checks, errors + 1);
        $fatal(1, "timeout");
    end

endmodule

// File: doc/spi_reg_bridge.md
Name: spi_reg_bridge

Overview:
- Byte-level command decoder that sits directly downstream of the SPI slave shifter.
- Consumes the shifter's received-byte strobe and byte, and turns each SPI transaction into single-byte reads or writes on a simple 8-bit register bus with an auto-incrementing address.
- Drives the shifter's transmit byte input: a status byte while idle, and prefetched read data during reads.

Parameters:
- AW, 7, register bus address width (1..7); the command byte carries a 7-bit address, and only the low AW bits are used.
- STATUS_ID, 7'h5A, constant placed in the low 7 bits of the status byte.

Ports:
- clk, input, 1, system clock.
- rst_n, input, 1, reset; asynchronous assert, active-low.
- ss, input, 1, raw SPI slave select (active-low); synchronized internally.
- rx_done, input, 1, one-cycle pulse from the shifter: a byte was received.
- rx_byte, input, 8, received byte; valid when rx_done=1.
- tx_byte, output, 8, byte the shifter loads for its next transmission.
- bus_addr, output, AW, register address.
- bus_wdata, output, 8, write data.
- bus_wr, output, 1, write request; held until bus_ack.
- bus_rd, output, 1, read request; held until bus_ack.
- bus_rdata, input, 8, read data; valid with bus_ack.
- bus_ack, input, 1, one-cycle completion of the current request.
- busy, output, 1, high in any state other than IDLE.

Behaviour:
- Reset (rst_n low, immediate): state=IDLE, tx_byte={1'b0,STATUS_ID}, bus_wr=0, bus_rd=0, bus_addr=0, bus_wdata=0, err=0, busy=0.
- ss goes through a 2-FF synchronizer; ss_s is the synchronized value. A rising edge of ss_s is end-of-transaction (EOT).
- States:
  - IDLE: tx_byte={err,STATUS_ID}. Falling ss_s -> CMD.
  - CMD: on rx_done, decode rx_byte[7] (1=write, 0=read) and address a=rx_byte[AW-1:0], then clear err.
    - Write: ptr=a, go to WR.
    - Read: issue bus_rd at a, set ptr=a+1, go to RD.
  - WR: each rx_done issues bus_wr with bus_addr=ptr and bus_wdata=rx_byte, then ptr=ptr+1.
  - RD: each rx_done issues bus_rd at ptr, then ptr=ptr+1. MOSI data is ignored. On bus_ack: tx_byte<=bus_rdata.
  - DRAIN: entered on EOT while a request is outstanding. The request is held until bus_ack; rdata is discarded. Then go to IDLE.
- EOT with no outstanding request: go to IDLE next cycle and restore the status byte.
- ptr arithmetic is modulo 2^AW; AW'h..FF wraps to 0.
- Bus rules:
  - At most one outstanding request; bus_addr/bus_wdata are stable while bus_rd or bus_wr is high.
  - A request asserts the cycle after rx_done.
  - Request deasserts the cycle after bus_ack.
  - bus_rd and bus_wr are never high together.
- Overrun: rx_done while a request is still outstanding.
  - The new byte is dropped, and ptr does not advance.
  - err is set, and stays set until the next command byte is received.
- Read latency on the wire:
  - MISO byte 1 = status; byte 2 = status (turnaround).
  - Byte 3 = D[a], byte 4 = D[a+1], and so on.
  - A read must ack within 8 SCK periods, otherwise overrun.
- The final prefetch of a read transaction is performed but never shifted out. Read-side-effect registers must tolerate this.
- rx_done in IDLE/DRAIN is ignored. A command byte with ss high is not possible.
- Simultaneous rx_done and bus_ack: the ack completes first, then the new request issues next cycle with no overrun.
- Simultaneous EOT and rx_done: the byte is processed, then EOT is handled.
- Reset mid-transaction: the bus request drops immediately. The bus side must accept an abandoned request.

Decomposition:
- Shared package spi_pkg:
  - state encoding (IDLE, CMD, WR, RD, DRAIN);
  - CMD_WR_BIT=7;
  - default STATUS_ID.
- One sub-module, sync2: a generic 2-FF synchronizer with async active-low reset, reset value 1 for ss. It is reused for other pad inputs.

Test Plan:
- Write burst:
  - Stimulus: ss low; bytes 0x85, 0x11, 0x22, 0x33; bus_ack 2 cycles after each request.
  - Required: bus_wr to addr 5/6/7 with data 0x11/0x22/0x33; ss high -> IDLE; tx_byte=0x5A.
- Read burst:
  - Stimulus: model memory D[0x10]=0xAB, D[0x11]=0xCD; bytes 0x10, 0x00, 0x00, 0x00.
  - Required: tx_byte at byte ends = 0x5A, 0xAB, 0xCD; bus_rd addresses 0x10, 0x11, 0x12, 0x13 (the last one is discarded).
- Wrap:
  - Stimulus: write command 0xFE then 3 data bytes, AW=7.
  - Required: addresses 0x7E, 0x7F, 0x00.
- Overrun:
  - Stimulus: stall bus_ack; send 2 write data bytes back-to-back.
  - Required: the second byte is dropped; the next transaction's first MISO byte = 0xDA; err clears after that transaction's command byte.
- EOT with pending read:
  - Stimulus: deassert ss while bus_rd is waiting; ack 10 cycles later.
  - Required: DRAIN holds the request; tx_byte stays 0x5A; busy falls after the ack.
- Async reset:
  - Stimulus: pull rst_n low mid-write with bus_wr high.
  - Required: all outputs reach reset values without a clk edge; normal operation on release.
